complex_recursion_bank: RTL and testbench

//  Multi-channel fixed-point complex first-order recursion y[n] = a_ch*y[n-1] + x[n] for the

---
 rtl/cbf_pkg.sv | 41 ++++
 rtl/cplx_mult_pipe.sv | 42 ++++
 rtl/complex_recursion_bank.sv | 178 +++++++++++++++++
 tb/tb_complex_recursion_bank.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbf_pkg.sv
// Shared fixed-point types, widths and rounding/limiting helpers for the
// control-bounded filter back end.
package cbf_pkg;

  localparam int DW_DEF    = 16;
  localparam int CW_DEF    = 18;
  localparam int CF_DEF    = 16;
  localparam int RECUR_LAT = 3;

  typedef struct packed {
    logic signed [DW_DEF-1:0] r;
    logic signed [DW_DEF-1:0] i;
  } cplx_t;

  typedef logic signed [63:0] wide_t;

  function automatic wide_t round_half_up(input wide_t p, input int cf);
    wide_t half;
    half = wide_t'(1) <<< (cf - 1);
    return (p + half) >>> cf;
  endfunction

  function automatic logic out_of_range(input wide_t v, input int dw);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (dw - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic wide_t clamp(input wide_t v, input int dw);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cplx_mult_pipe.sv
// Registered four-product complex multiplier: every cross product of a and b
// is captured at full width one cycle after the operands are presented.
module cplx_mult_pipe #(
  parameter int AW = 16,
  parameter int BW = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    a_r,
  input  logic [AW-1:0]    a_i,
  input  logic [BW-1:0]    b_r,
  input  logic [BW-1:0]    b_i,
  output logic [AW+BW-1:0] p_rr,
  output logic [AW+BW-1:0] p_ii,
  output logic [AW+BW-1:0] p_ri,
  output logic [AW+BW-1:0] p_ir
);

  localparam int PW = AW + BW;

  logic [PW-1:0] ar_x, ai_x, br_x, bi_x;

  assign ar_x = {{BW{a_r[AW-1]}}, a_r};
  assign ai_x = {{BW{a_i[AW-1]}}, a_i};
  assign br_x = {{AW{b_r[BW-1]}}, b_r};
  assign bi_x = {{AW{b_i[BW-1]}}, b_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else begin
      p_rr <= $signed(ar_x) * $signed(br_x);
      p_ii <= $signed(ai_x) * $signed(bi_x);
      p_ri <= $signed(ar_x) * $signed(bi_x);
      p_ir <= $signed(ai_x) * $signed(br_x);
    end
  end

endmodule

// File: rtl/complex_recursion_bank.sv
// Time-multiplexed bank of complex recursions y = a_ch*y + x on one pipelined MAC.
// Define COMPLEX_RECURSION_SAT_EN to clamp out-of-range results and drive sat; otherwise results wrap.
module complex_recursion_bank
  import cbf_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int CW          = CW_DEF,
  parameter int CF          = CF_DEF,
  parameter int CH          = 4,
  parameter int COEF_R_INIT = 0,
  parameter int COEF_I_INIT = 0,
  localparam int CHW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic           in_init,
  input  logic [DW-1:0]  in_r,
  input  logic [DW-1:0]  in_i,
  input  logic           coef_we,
  input  logic [CHW-1:0] coef_ch,
  input  logic [CW-1:0]  coef_r,
  input  logic [CW-1:0]  coef_i,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_r,
  output logic [DW-1:0]  out_i,
  output logic           sat
);

  localparam int PW = DW + CW;
  localparam int SW = PW + 1;
  localparam logic [CHW:0] CH_LIM = (CHW+1)'(CH);

  logic [DW-1:0]  st_r [CH];
  logic [DW-1:0]  st_i [CH];
  logic [CW-1:0]  cf_r [CH];
  logic [CW-1:0]  cf_i [CH];

  logic           in_ok, hazard, accept;
  logic [CHW-1:0] rd_idx;
  logic [PW-1:0]  p_rr, p_ii, p_ri, p_ir;

  logic           s1_valid, s1_init;
  logic [CHW-1:0] s1_ch;
  logic [DW-1:0]  s1_xr, s1_xi;
  logic           s2_valid, s2_init;
  logic [CHW-1:0] s2_ch;
  logic [DW-1:0]  s2_xr, s2_xi;
  logic [SW-1:0]  s2_pr, s2_pi;

  wide_t          fb_r, fb_i, sum_r, sum_i;
  logic [DW-1:0]  y_r, y_i;

  // A channel with a sample still in S1 or S2 has stale state, so it must wait.
  assign in_ok    = {1'b0, in_ch} < CH_LIM;
  assign hazard   = (s1_valid && (s1_ch == in_ch)) || (s2_valid && (s2_ch == in_ch));
  assign in_ready = !rst && in_ok && !hazard;
  assign accept   = in_valid && in_ready;
  assign rd_idx   = in_ok ? in_ch : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        cf_r[c] <= CW'(COEF_R_INIT);
        cf_i[c] <= CW'(COEF_I_INIT);
      end
    end else if (coef_we && ({1'b0, coef_ch} < CH_LIM)) begin
      cf_r[coef_ch] <= coef_r;
      cf_i[coef_ch] <= coef_i;
    end
  end

  cplx_mult_pipe #(.AW(DW), .BW(CW)) u_mult (
    .clk  (clk),
    .rst  (rst),
    .a_r  (st_r[rd_idx]),
    .a_i  (st_i[rd_idx]),
    .b_r  (cf_r[rd_idx]),
    .b_i  (cf_i[rd_idx]),
    .p_rr (p_rr),
    .p_ii (p_ii),
    .p_ri (p_ri),
    .p_ir (p_ir)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_init  <= 1'b0;
      s1_ch    <= '0;
      s1_xr    <= '0;
      s1_xi    <= '0;
      s2_valid <= 1'b0;
      s2_init  <= 1'b0;
      s2_ch    <= '0;
      s2_xr    <= '0;
      s2_xi    <= '0;
      s2_pr    <= '0;
      s2_pi    <= '0;
    end else begin
      s1_valid <= accept;
      s1_init  <= in_init;
      s1_ch    <= in_ch;
      s1_xr    <= in_r;
      s1_xi    <= in_i;
      s2_valid <= s1_valid;
      s2_init  <= s1_init;
      s2_ch    <= s1_ch;
      s2_xr    <= s1_xr;
      s2_xi    <= s1_xi;
      s2_pr    <= {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
      s2_pi    <= {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    end
  end

`ifdef COMPLEX_RECURSION_SAT_EN
  logic clip_r, clip_i;
`endif

  always_comb begin
    fb_r = '0;
    fb_i = '0;
    if (!s2_init) begin
      fb_r = round_half_up({{(64-SW){s2_pr[SW-1]}}, s2_pr}, CF);
      fb_i = round_half_up({{(64-SW){s2_pi[SW-1]}}, s2_pi}, CF);
    end
    sum_r = fb_r + {{(64-DW){s2_xr[DW-1]}}, s2_xr};
    sum_i = fb_i + {{(64-DW){s2_xi[DW-1]}}, s2_xi};
`ifdef COMPLEX_RECURSION_SAT_EN
    y_r    = DW'(clamp(sum_r, DW));
    y_i    = DW'(clamp(sum_i, DW));
    clip_r = out_of_range(sum_r, DW);
    clip_i = out_of_range(sum_i, DW);
`else
    y_r = DW'(sum_r);
    y_i = DW'(sum_i);
`endif
  end

  // The result and the channel's state are committed on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_r     <= '0;
      out_i     <= '0;
      for (int c = 0; c < CH; c++) begin
        st_r[c] <= '0;
        st_i[c] <= '0;
      end
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_ch      <= s2_ch;
        out_r       <= y_r;
        out_i       <= y_i;
        st_r[s2_ch] <= y_r;
        st_i[s2_ch] <= y_i;
      end
    end
  end

`ifdef COMPLEX_RECURSION_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat <= 1'b0;
    end else if (s2_valid && (clip_r || clip_i)) begin
      sat <= 1'b1;
    end
  end
`else
  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_complex_recursion_bank.sv
// Self-checking bench for complex_recursion_bank: directed literal cases plus a
// randomized stream compared every cycle against a behavioural channel model.
module tb_complex_recursion_bank;
  import cbf_pkg::*;

  localparam int CH   = 4;
  localparam int DW   = 16;
  localparam int CW   = 18;
  localparam int CF   = 16;
  localparam longint HALF = 64'sd1 <<< (CF - 1);
`ifdef COMPLEX_RECURSION_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_ch = '0;
  logic          in_init = 1'b0;
  logic [DW-1:0] in_r = '0;
  logic [DW-1:0] in_i = '0;
  logic          coef_we = 1'b0;
  logic [1:0]    coef_ch = '0;
  logic [CW-1:0] coef_r = '0;
  logic [CW-1:0] coef_i = '0;
  logic          out_valid;
  logic [1:0]    out_ch;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic          sat;

  complex_recursion_bank #(
    .DW(DW), .CW(CW), .CF(CF), .CH(CH), .COEF_R_INIT(0), .COEF_I_INIT(0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_init(in_init), .in_r(in_r), .in_i(in_i), .coef_we(coef_we), .coef_ch(coef_ch),
    .coef_r(coef_r), .coef_i(coef_i), .out_valid(out_valid), .out_ch(out_ch),
    .out_r(out_r), .out_i(out_i), .sat(sat)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    int     ch;
    longint r;
    longint i;
    bit     clip;
  } exp_t;

  exp_t   expm [int];
  longint m_sr [CH];
  longint m_si [CH];
  longint m_cr [CH];
  longint m_ci [CH];
  int     last_acc [CH];
  int     cyc;
  bit     m_sat;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  function automatic bit outOfRange(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic longint limitv(input longint v);
    longint t;
    if (SAT_ON) begin
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
    end
    t = v & 65535;
    if (t >= 32768) t = t - 65536;
    return t;
  endfunction

  // Channel model: each accepted sample is evaluated immediately and its result
  // is filed under the cycle on which it must appear at the outputs.
  always @(posedge clk or posedge rst) begin : model
    int     c;
    bit     rdy;
    longint fr, fi;
    exp_t   e;
    if (rst) begin
      cyc = 0;
      expm.delete();
      for (int k = 0; k < CH; k++) begin
        m_sr[k] = 0; m_si[k] = 0; m_cr[k] = 0; m_ci[k] = 0; last_acc[k] = -100;
      end
    end else begin
      c   = int'(in_ch);
      rdy = (c < CH) && (cyc - last_acc[c] >= 2);
      cyc++;
      if (in_valid && rdy) begin
        if (in_init) begin
          fr = 0; fi = 0;
        end else begin
          fr = (m_sr[c] * m_cr[c] - m_si[c] * m_ci[c] + HALF) >>> CF;
          fi = (m_sr[c] * m_ci[c] + m_si[c] * m_cr[c] + HALF) >>> CF;
        end
        fr = fr + longint'($signed(in_r));
        fi = fi + longint'($signed(in_i));
        e.ch   = c;
        e.r    = limitv(fr);
        e.i    = limitv(fi);
        e.clip = SAT_ON && (outOfRange(fr) || outOfRange(fi));
        m_sr[c] = e.r;
        m_si[c] = e.i;
        last_acc[c] = cyc;
        expm[cyc + 2] = e;
      end
      if (coef_we) begin
        m_cr[int'(coef_ch)] = longint'($signed(coef_r));
        m_ci[int'(coef_ch)] = longint'($signed(coef_i));
      end
    end
  end

  always @(negedge clk) begin : compare
    int   c;
    bit   rdy;
    exp_t e;
    if (rst) begin
      m_sat = 1'b0;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_r", longint'($signed(out_r)), 0);
      checkOutput("rst_sat", sat, 0);
      checkOutput("rst_in_ready", in_ready, 0);
    end else begin
      c   = int'(in_ch);
      rdy = (c < CH) && (cyc - last_acc[c] >= 2);
      checkOutput("in_ready", in_ready, rdy);
      if (expm.exists(cyc)) begin
        e = expm[cyc];
        checkOutput("out_valid", out_valid, 1);
        checkOutput("out_ch", out_ch, e.ch);
        checkOutput("out_r", longint'($signed(out_r)), e.r);
        checkOutput("out_i", longint'($signed(out_i)), e.i);
        if (e.clip) m_sat = 1'b1;
      end else begin
        checkOutput("out_valid_idle", out_valid, 0);
      end
      checkOutput("sat", sat, m_sat);
    end
  end

  task automatic applyStimulus(input bit v, input int ch, input bit init, input int xr, input int xi,
                               input bit we, input int cch, input int cr, input int ci);
    in_valid = v;
    in_ch    = 2'(ch);
    in_init  = init;
    in_r     = 16'(xr);
    in_i     = 16'(xi);
    coef_we  = we;
    coef_ch  = 2'(cch);
    coef_r   = 18'(cr);
    coef_i   = 18'(ci);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_init  = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic waitOut(input string name, input int ch, input int er, input int ei);
    bit seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (out_valid && (out_ch == 2'(ch))) seen = 1'b1;
    end
    checkOutput({name, "_seen"}, seen, 1);
    if (seen) begin
      checkOutput({name, "_r"}, longint'($signed(out_r)), er);
      checkOutput({name, "_i"}, longint'($signed(out_i)), ei);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendCheck(input string name, input int ch, input bit init, input int xr, input int xi,
                           input int er, input int ei);
    applyStimulus(1'b1, ch, init, xr, xi, 1'b0, 0, 0, 0);
    waitOut(name, ch, er, ei);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] impulse response, coefficient 0.5");
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, 0, 32768, 0);
    sendCheck("imp0", 0, 1'b1, 1000, 0, 1000, 0);
    sendCheck("imp1", 0, 1'b0, 0, 0, 500, 0);
    sendCheck("imp2", 0, 1'b0, 0, 0, 250, 0);
    sendCheck("imp3", 0, 1'b0, 0, 0, 125, 0);

    $display("[TB] rotation, coefficient j");
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, 1, 0, 65536);
    sendCheck("rot0", 1, 1'b1, 100, 0, 100, 0);
    sendCheck("rot1", 1, 1'b0, 0, 0, 0, 100);
    sendCheck("rot2", 1, 1'b0, 0, 0, -100, 0);
    sendCheck("rot3", 1, 1'b0, 0, 0, 0, -100);

    $display("[TB] same-channel hazard");
    in_valid = 1'b1; in_ch = 2'd2; in_init = 1'b1; in_r = 16'd5; in_i = 16'd0;
    @(posedge clk); #1;
    in_init = 1'b0; in_r = 16'd9; in_i = 16'd3;
    @(negedge clk);
    checkOutput("hz_ready_k1", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("hz_ready_k2", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("hz_ready_k3", in_ready, 1);
    checkOutput("hz_a_valid", out_valid, 1);
    checkOutput("hz_a_r", longint'($signed(out_r)), 5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitOut("hz_b", 2, 9, 3);

    $display("[TB] saturation, coefficient 1.0");
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, 2, 65536, 0);
    sendCheck("sat0", 2, 1'b1, 30000, 0, 30000, 0);
    sendCheck("sat1", 2, 1'b0, 30000, 0, SAT_ON ? 32767 : -5536, 0);
    checkOutput("sat_flag", sat, SAT_ON ? 1 : 0);

    $display("[TB] init and coefficient write alongside a sample");
    applyStimulus(1'b1, 3, 1'b1, 200, -50, 1'b1, 3, 65536, 0);
    waitOut("ini0", 3, 200, -50);
    applyStimulus(1'b1, 3, 1'b0, 0, 0, 1'b1, 3, 32768, 0);
    waitOut("old_coef", 3, 200, -50);
    sendCheck("new_coef", 3, 1'b0, 0, 0, 100, -25);

    $display("[TB] randomized stream");
    for (int n = 0; n < 700; n++) begin
      if (n == 400) begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_sat", sat, 0);
        @(posedge clk); #1;
        rst = 1'b0;
      end
      applyStimulus(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                    ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 140000)) - 70000, int'($urandom_range(0, 140000)) - 70000);
    end
    repeat (5) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0);

    $display("[TB] reset restores coefficients and states");
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, 0, 40000, -20000);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sendCheck("post_rst_coef", 0, 1'b0, 123, -45, 123, -45);
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, 1, 65536, 0);
    sendCheck("post_rst_state", 1, 1'b0, 7, -3, 7, -3);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
